data_mem_mmio: RTL and testbench
================================

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256; data RAM depth in 32-bit words (power of two, max 256).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port MemWrite  input  1  store strobe from the core.
REQ-005 SHALL have port MemRead  input  1  load strobe from the core.
REQ-006 SHALL have port ALUResult  input  32  byte address from the core; bits [1:0] ignored.
REQ-007 SHALL have port WriteData  input  32  store data from the core.
REQ-008 SHALL have port ReadData  output  32  load data returned to the core in the same cycle.
REQ-009 SHALL have port result_data  output  32  value pushed by the program to the RESULT register.
REQ-010 SHALL have port result_valid  output  1  result_data holds an unconsumed value.
REQ-011 SHALL have port result_ready  input  1  the consumer accepts result_data this cycle.
REQ-012 SHALL have port overflow_err  output  1  sticky flag: a result push was dropped.

Function
REQ-013 SHALL decode the address map: 0x000-0x3FC RAM (index ALUResult[9:2] mod RAM_WORDS); 0x400 RESULT; 0x404 STATUS; 0x408 CYCLE; every other address unmapped.
REQ-014 SHALL drive ReadData combinationally: 0 when MemRead=0; RAM word; RESULT = result_data; STATUS = {30'b0, overflow_err, result_valid}; CYCLE = cycle counter; unmapped = 0.
REQ-015 SHALL write a RAM word at the clock edge when MemWrite=1 and the address is in RAM; a same-cycle read returns the pre-write value.
REQ-016 SHALL ignore stores to CYCLE and to unmapped addresses.
REQ-017 SHALL treat a store to RESULT as a push: when result_valid=0, or result_valid=1 with result_ready=1, load result_data with WriteData and set result_valid=1 at the next edge.
REQ-018 SHALL drop a push when result_valid=1 and result_ready=0, keep result_data unchanged, and set overflow_err=1.
REQ-019 SHALL clear result_valid at the edge where result_valid=1, result_ready=1 and no push occurs; result_ready while result_valid=0 has no effect.
REQ-020 SHALL clear overflow_err on a store to STATUS with WriteData[1]=1; a drop in the same cycle takes priority and leaves overflow_err=1.
REQ-021 SHALL keep a 32-bit free-running cycle counter incremented every non-reset cycle, wrapping 0xFFFFFFFF -> 0.
REQ-022 SHALL give a store precedence over a load when MemWrite and MemRead are both 1: the store side effect occurs and ReadData shows pre-edge state.

Reset
REQ-023 SHALL, while reset=1 at an edge, set result_data=0, result_valid=0, overflow_err=0 and cycle counter=0; pushes in that cycle are discarded.
REQ-024 SHALL NOT reset RAM contents; reset asserted mid-program leaves RAM unchanged.

Structure
REQ-025 SHALL place address constants (RAM_BASE, ADDR_RESULT, ADDR_STATUS, ADDR_CYCLE) and STATUS bit positions in a shared package used by this block and its testbench.
REQ-026 SHALL implement the RAM array in one sub-module, dmem_ram (synchronous write, asynchronous read); decode, RESULT handshake and counter stay in data_mem_mmio.

Verification
REQ-027 SHALL cover store 0xDEADBEEF to 0x010, then load 0x010 -> ReadData=0xDEADBEEF; load 0x010 with MemRead=0 -> ReadData=0.
REQ-028 SHALL cover push 0x00000005 to 0x400 with result_ready=0 -> result_valid=1 and result_data=5 next cycle; STATUS read=0x1.
REQ-029 SHALL cover a second push 0x7 while result_valid=1 and result_ready=0 -> result_data stays 5, overflow_err=1, STATUS=0x3; store 0x2 to 0x404 -> overflow_err=0.
REQ-030 SHALL cover a push 0x9 in the same cycle as result_ready=1 with result_valid=1 -> result_data=9, result_valid=1, no overflow; ready alone on the next cycle -> result_valid=0.
REQ-031 SHALL cover reset for 2 cycles after 10 run cycles -> CYCLE read=0 on the first cycle after release and 3 after three more cycles; RAM word at 0x010 still 0xDEADBEEF.
REQ-032 SHALL cover a store to unmapped 0x800, then load 0x800 -> ReadData=0 and no RAM word changes.

Source files
------------

// File: rtl/data_mem_mmio_pkg.sv
// Shared address map, STATUS bit layout and address decode for the data memory
// with memory-mapped RESULT/STATUS/CYCLE registers.
package data_mem_mmio_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] ADDR_RESULT = 32'h0000_0400;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_0404;
    localparam logic [31:0] ADDR_CYCLE  = 32'h0000_0408;

    localparam int unsigned STATUS_VALID_BIT = 0;
    localparam int unsigned STATUS_OVF_BIT   = 1;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_RESULT,
        RGN_STATUS,
        RGN_CYCLE,
        RGN_NONE
    } region_e;

    // RAM occupies the first 1 KiB; registers match on word address only.
    function automatic region_e decode_addr(input logic [31:0] addr);
        if (addr[31:10] == RAM_BASE[31:10])
            return RGN_RAM;
        else if (addr[31:2] == ADDR_RESULT[31:2])
            return RGN_RESULT;
        else if (addr[31:2] == ADDR_STATUS[31:2])
            return RGN_STATUS;
        else if (addr[31:2] == ADDR_CYCLE[31:2])
            return RGN_CYCLE;
        else
            return RGN_NONE;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data RAM: synchronous write, asynchronous read, no reset.
module dmem_ram #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_mmio.sv
// Data memory with RESULT push register (valid/ready handshake, sticky overflow),
// STATUS readback and a free-running cycle counter.
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] result_data,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        overflow_err
);

    localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    region_e     rgn;
    logic [7:0]  word_idx;
    logic [31:0] ram_rdata;
    logic [31:0] cycle_cnt;
    logic        ram_we;
    logic        push;
    logic        accept;
    logic        drop;
    logic        ovf_clear;

    assign rgn       = decode_addr(ALUResult);
    assign word_idx  = ALUResult[9:2] & 8'(RAM_WORDS - 1);
    assign ram_we    = MemWrite && (rgn == RGN_RAM);
    assign push      = MemWrite && (rgn == RGN_RESULT);
    assign accept    = push && (!result_valid || result_ready);
    assign drop      = push && result_valid && !result_ready;
    assign ovf_clear = MemWrite && (rgn == RGN_STATUS) && WriteData[STATUS_OVF_BIT];

    dmem_ram #(
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (word_idx[AW-1:0]),
        .wdata (WriteData),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            result_data  <= '0;
            result_valid <= 1'b0;
            overflow_err <= 1'b0;
            cycle_cnt    <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (accept) begin
                result_data  <= WriteData;
                result_valid <= 1'b1;
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
            // A drop outranks a same-cycle clear so the loss is never hidden.
            if (drop)
                overflow_err <= 1'b1;
            else if (ovf_clear)
                overflow_err <= 1'b0;
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            case (rgn)
                RGN_RAM:    ReadData = ram_rdata;
                RGN_RESULT: ReadData = result_data;
                RGN_STATUS: begin
                    ReadData[STATUS_VALID_BIT] = result_valid;
                    ReadData[STATUS_OVF_BIT]   = overflow_err;
                end
                RGN_CYCLE:  ReadData = cycle_cnt;
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scenario bench for data_mem_mmio: expected values are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_data_mem_mmio;
    import data_mem_mmio_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic        result_ready = 1'b0;
    logic [31:0] ReadData;
    logic [31:0] result_data;
    logic        result_valid;
    logic        overflow_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    data_mem_mmio #(.RAM_WORDS(256)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .ALUResult    (ALUResult),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .result_data  (result_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overflow_err (overflow_err)
    );

    // Inputs change on the falling edge; combinational outputs are sampled 1 ns later.
    task automatic drive(input logic rst, input logic we, input logic re,
                         input logic [31:0] addr, input logic [31:0] wd, input logic rdy);
        @(negedge clk);
        reset = rst; MemWrite = we; MemRead = re;
        ALUResult = addr; WriteData = wd; result_ready = rdy;
        #1;
    endtask

    task automatic expect_val(input string name, input logic [31:0] v);
        sb.push_back('{name, v});
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        expect_val("rst_cycle", 32'd0);
        expect_val("rst_valid", 32'd0);
        expect_val("rst_ovf", 32'd0);
        expect_val("rst_rdata", 32'd0);
        drive(0, 0, 1, ADDR_CYCLE, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, result_valid} !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result_valid, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, overflow_err} !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, overflow_err, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if (result_data !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result_data, e.exp); end
    endtask

    task automatic test_ram();
        exp_t e;
        drive(0, 1, 0, 32'h010, 32'hDEADBEEF, 0);
        expect_val("ram_load", 32'hDEADBEEF);
        drive(0, 0, 1, 32'h010, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        expect_val("ram_noread", 32'h0);
        drive(0, 0, 0, 32'h010, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        // Load and store together: pre-write value visible, new value after the edge.
        expect_val("ram_rw_old", 32'hDEADBEEF);
        expect_val("ram_rw_new", 32'h12345678);
        drive(0, 1, 1, 32'h010, 32'h12345678, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        drive(0, 0, 1, 32'h013, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        drive(0, 1, 0, 32'h010, 32'hDEADBEEF, 0);
        expect_val("ram_other_word", 32'hCAFE0001);
        drive(0, 1, 0, 32'h3FC, 32'hCAFE0001, 0);
        drive(0, 0, 1, 32'h3FC, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
    endtask

    task automatic test_result_push();
        exp_t e;
        drive(0, 1, 0, ADDR_RESULT, 32'h5, 0);
        expect_val("push_valid", 32'h1);
        expect_val("push_data", 32'h5);
        expect_val("push_status", 32'h1);
        drive(0, 0, 1, ADDR_STATUS, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, result_valid} !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result_valid, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if (result_data !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result_data, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        expect_val("push_readback", 32'h5);
        drive(0, 0, 1, ADDR_RESULT, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
    endtask

    task automatic test_overflow();
        exp_t e;
        drive(0, 1, 0, ADDR_RESULT, 32'h7, 0);
        expect_val("ovf_data_kept", 32'h5);
        expect_val("ovf_flag", 32'h1);
        expect_val("ovf_status", 32'h3);
        drive(0, 0, 1, ADDR_STATUS, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (result_data !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result_data, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, overflow_err} !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, overflow_err, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        drive(0, 1, 0, ADDR_STATUS, 32'h2, 0);
        expect_val("ovf_cleared", 32'h0);
        expect_val("ovf_clr_status", 32'h1);
        drive(0, 0, 1, ADDR_STATUS, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, overflow_err} !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, overflow_err, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive(0, 1, 0, ADDR_RESULT, 32'h9, 1);
        expect_val("b2b_data", 32'h9);
        expect_val("b2b_valid", 32'h1);
        expect_val("b2b_no_ovf", 32'h0);
        drive(0, 0, 0, 0, 0, 1);
        e = sb.pop_front(); n_cmp++;
        if (result_data !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result_data, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, result_valid} !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result_valid, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, overflow_err} !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, overflow_err, e.exp); end
        expect_val("drain_valid", 32'h0);
        drive(0, 0, 0, 0, 0, 1);
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, result_valid} !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result_valid, e.exp); end
        expect_val("idle_ready_valid", 32'h0);
        expect_val("idle_ready_data", 32'h9);
        drive(0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, result_valid} !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result_valid, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if (result_data !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result_data, e.exp); end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, ADDR_RESULT, 32'hAA, 0);
        drive(1, 1, 0, ADDR_RESULT, 32'hBB, 0);
        expect_val("mid_cycle0", 32'd0);
        expect_val("mid_push_dropped", 32'h0);
        drive(0, 0, 1, ADDR_CYCLE, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, result_valid} !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, result_valid, e.exp); end
        drive(0, 0, 1, ADDR_CYCLE, 0, 0);
        drive(0, 0, 1, ADDR_CYCLE, 0, 0);
        expect_val("mid_cycle3", 32'd3);
        drive(0, 0, 1, ADDR_CYCLE, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        expect_val("mid_ram_kept", 32'hDEADBEEF);
        drive(0, 0, 1, 32'h010, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
    endtask

    task automatic test_unmapped();
        exp_t e;
        drive(0, 1, 0, 32'h000, 32'h11111111, 0);
        drive(0, 1, 0, 32'h800, 32'hBADBAD00, 0);
        drive(0, 1, 0, 32'h810, 32'hBADBAD10, 0);
        expect_val("unmap_read", 32'h0);
        drive(0, 0, 1, 32'h800, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        expect_val("unmap_ram0", 32'h11111111);
        drive(0, 0, 1, 32'h000, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        expect_val("unmap_ram10", 32'hDEADBEEF);
        drive(0, 0, 1, 32'h010, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
        expect_val("unmap_40c", 32'h0);
        drive(0, 0, 1, 32'h40C, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (ReadData !== e.exp) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, ReadData, e.exp); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_result_push();
        test_overflow();
        test_back_to_back();
        test_reset_midrun();
        test_unmapped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
